mips32_mem_responder: RTL and testbench
=======================================

Name: mips32_mem_responder

Overview:
- Memory-side responder for the MIPS32 pipeline's instruction-fetch and load/store accesses.
- Replaces direct array indexing with a request/acknowledge handshake on two ports: fetch (read-only) and data (read/write).
- Both ports share one single-ported word array, with arbitration and programmable wait states.
- Lets the core later be modified to stall on memory instead of assuming zero-latency access.

Parameters:
- DEPTH, 1024, number of 32-bit words in the backing array (word-addressed).
- AW, 10, index width; must satisfy 2**AW >= DEPTH.
- WAIT_STATES, 0, extra cycles inserted between request acceptance and response, legal range 0..15.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- if_req  input  1  fetch request; held high with stable if_addr until if_ack seen.
- if_addr  input  32  fetch word address.
- if_ack  output  1  one-cycle pulse: fetch response valid.
- if_rdata  output  32  fetched word; registered, holds until next fetch response.
- if_err  output  1  valid with if_ack: address out of range.
- d_req  input  1  data request; held with stable d_we/d_addr/d_wdata until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  32  data word address.
- d_wdata  input  32  store data.
- d_ack  output  1  one-cycle pulse: data response valid / store committed.
- d_rdata  output  32  load data; registered, holds until next data response.
- d_err  output  1  valid with d_ack: address out of range.
- busy  output  1  high while the FSM is not in IDLE.

Behaviour:
- Reset values:
  - if_ack, d_ack, if_err, d_err, busy: 0.
  - if_rdata, d_rdata: 0.
  - FSM: IDLE.
  - last_grant: FETCH.
  - wait counter: 0.
  - Array contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE: samples if_req/d_req each cycle.
  - On any request: latch the grant, address, we and wdata.
  - Next state is WAIT if WAIT_STATES > 0 (counter loaded with WAIT_STATES), else RESP.
- WAIT: counter decrements each cycle; when it reaches 1, next state is RESP. Port inputs are ignored.
- RESP: array accessed with the latched values; the granted port's ack is high this cycle only; next state is IDLE.
- Latency: a request first sampled in IDLE in cycle N is acked in cycle N+1+WAIT_STATES.
  - Requests held continuously on one port are acked every WAIT_STATES+2 cycles.
- Arbitration when both requests are sampled high in IDLE:
  - Grant goes to the port not granted most recently (last_grant).
  - Since last_grant resets to FETCH, the first contention after reset goes to data.
  - A single requester always wins, and last_grant updates on every grant.
- Read: rdata of the granted port is loaded from array[addr[AW-1:0]] in RESP; the other port's rdata is unchanged.
- Write: array[addr[AW-1:0]] <= wdata at the RESP edge; d_rdata is unchanged on stores.
- Range check: addr >= DEPTH, evaluated on the full 32 bits, means error.
  - Error response: ack with err=1, rdata forced to 0, no array write.
- err is 0 on every successful ack and holds 0 when ack is low.
- Requester protocol:
  - Drop req on the edge after the ack cycle.
  - A req still high when IDLE is re-entered is a new request.
  - Changing addr/data while req is high and unacked is illegal; the captured values are used.
- Reset mid-operation (rst in WAIT or RESP): FSM returns to IDLE and no ack issues.
  - A pending store is discarded unless its RESP edge already completed.
  - rst has priority over the RESP write in the same cycle.
- WAIT_STATES = 0: IDLE and RESP alternate; busy is high only in RESP cycles.

Test Plan:
1. WAIT_STATES=2: store d_addr=5, d_wdata=0xDEADBEEF sampled cycle N -> d_ack=1 only in cycle N+3, d_err=0; then load addr 5 -> d_rdata=0xDEADBEEF.
2. After reset, if_req and d_req both high, held (if_addr=3, d_addr=7 load) -> acks alternate d, if, d, if..., each every WAIT_STATES+2 cycles; if_rdata/d_rdata are never cross-written.
3. Store d_addr=1024, d_wdata=0x1234 -> d_ack with d_err=1, d_rdata=0; read addr 0 shows its prior value unchanged. Fetch if_addr=0xFFFFFFFF -> if_err=1.
4. WAIT_STATES=3: store addr 9 = 0xA5A5A5A5 (old 0x11111111); assert rst for one cycle during WAIT -> no d_ack, busy=0 after reset, later load addr 9 -> 0x11111111.
5. WAIT_STATES=0: single-port back-to-back fetches at addresses 0,1,2 -> if_ack every 2 cycles, if_rdata matches preloaded words, busy toggles 0/1.

Source files
------------

// File: rtl/mips32_mem_responder.sv
// mips32_mem_responder
// Memory-side responder for the MIPS32 core. One single-ported word array is
// shared by the instruction-fetch port (read-only) and the load/store port
// (read/write). Each port uses a req/ack handshake. Requests are served one at
// a time, alternating grants when both ports compete, and each access takes a
// programmable number of wait states.
//
// Timing of one access:
//   IDLE  : the request is sampled and its grant, address, we and wdata latched
//   WAIT  : WAIT_STATES cycles; port inputs are ignored
//   RESP  : the granted port's ack is high for this cycle only
// Read data and err are registered on the edge that enters RESP. This way they
// are valid in the same cycle as ack. A store commits on the edge that leaves
// RESP, so a later access always sees it.

module mips32_mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int AW          = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_t;

    // Backing store. Reset leaves it untouched.
    logic [31:0] mem [DEPTH];

    // Sequencing state and the request latched in IDLE.
    state_t      state_q,     state_d;
    logic [3:0]  waitCnt_q,   waitCnt_d;
    grant_t      lastGrant_q, lastGrant_d;
    grant_t      grant_q,     grant_d;
    logic [31:0] addr_q,      addr_d;
    logic        we_q,        we_d;
    logic [31:0] wdata_q,     wdata_d;

    // Registered response outputs.
    logic        ifAck_q;
    logic        ifErr_q;
    logic [31:0] ifRdata_q;
    logic        dAck_q;
    logic        dErr_q;
    logic [31:0] dRdata_q;

    // The access presented at the edge that enters RESP. With zero wait
    // states this comes straight from the port inputs; otherwise it comes
    // from the latched copy.
    grant_t        pick;
    logic          enterResp;
    grant_t        accGrant;
    logic [31:0]   accAddr;
    logic          accWe;
    logic          accErr;
    logic [AW-1:0] accIdx;

    // Store commit conditions for the edge that leaves RESP.
    logic respErr;
    logic memWrite;

    // Arbitration: a lone requester always wins. On contention the grant goes
    // to the port that was not granted last time.
    always_comb begin
        pick = GRANT_FETCH;
        if (if_req && d_req) begin
            pick = (lastGrant_q == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
        end else if (d_req) begin
            pick = GRANT_DATA;
        end
    end

    // Next-state logic: latch the request in IDLE, count wait states, and
    // flag the edge on which the response registers must load.
    always_comb begin
        state_d     = state_q;
        waitCnt_d   = waitCnt_q;
        lastGrant_d = lastGrant_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        enterResp   = 1'b0;
        accGrant    = grant_q;
        accAddr     = addr_q;
        accWe       = we_q;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    grant_d     = pick;
                    lastGrant_d = pick;
                    addr_d      = (pick == GRANT_DATA) ? d_addr : if_addr;
                    we_d        = (pick == GRANT_DATA) ? d_we : 1'b0;
                    wdata_d     = d_wdata;
                    accGrant    = pick;
                    accAddr     = (pick == GRANT_DATA) ? d_addr : if_addr;
                    accWe       = (pick == GRANT_DATA) ? d_we : 1'b0;
                    if (WAIT_STATES > 0) begin
                        waitCnt_d = 4'(WAIT_STATES);
                        state_d   = ST_WAIT;
                    end else begin
                        state_d   = ST_RESP;
                        enterResp = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                waitCnt_d = waitCnt_q - 4'd1;
                if (waitCnt_q == 4'd1) begin
                    state_d   = ST_RESP;
                    enterResp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The range check uses the full 32-bit address, so aliases above DEPTH
    // never reach the array.
    always_comb begin
        accErr   = (accAddr >= 32'(DEPTH));
        accIdx   = accAddr[AW-1:0];
        respErr  = (addr_q >= 32'(DEPTH));
        memWrite = (state_q == ST_RESP) && (grant_q == GRANT_DATA) && we_q && !respErr;
    end

    // State and latched-request registers. Reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            waitCnt_q   <= 4'd0;
            lastGrant_q <= GRANT_FETCH;
            grant_q     <= GRANT_FETCH;
            addr_q      <= 32'd0;
            we_q        <= 1'b0;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            lastGrant_q <= lastGrant_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    // Response registers: pulse ack and err, and load rdata for the granted
    // port only. Errors force rdata to zero. Stores leave d_rdata alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            ifAck_q   <= 1'b0;
            ifErr_q   <= 1'b0;
            ifRdata_q <= 32'd0;
            dAck_q    <= 1'b0;
            dErr_q    <= 1'b0;
            dRdata_q  <= 32'd0;
        end else begin
            ifAck_q <= 1'b0;
            ifErr_q <= 1'b0;
            dAck_q  <= 1'b0;
            dErr_q  <= 1'b0;
            if (enterResp) begin
                if (accGrant == GRANT_FETCH) begin
                    ifAck_q   <= 1'b1;
                    ifErr_q   <= accErr;
                    ifRdata_q <= accErr ? 32'd0 : mem[accIdx];
                end else begin
                    dAck_q <= 1'b1;
                    dErr_q <= accErr;
                    if (accErr) begin
                        dRdata_q <= 32'd0;
                    end else if (!accWe) begin
                        dRdata_q <= mem[accIdx];
                    end
                end
            end
        end
    end

    // Store commit on the edge leaving RESP. A reset in that same cycle wins
    // and the store is dropped.
    always_ff @(posedge clk) begin
        if (!rst && memWrite) begin
            mem[addr_q[AW-1:0]] <= wdata_q;
        end
    end

    assign if_ack   = ifAck_q;
    assign if_err   = ifErr_q;
    assign if_rdata = ifRdata_q;
    assign d_ack    = dAck_q;
    assign d_err    = dErr_q;
    assign d_rdata  = dRdata_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips32_mem_responder.sv
// tb_mips32_mem_responder
// Three responders with WAIT_STATES of 2, 3 and 0 are exercised one after
// another. Each is driven by per-port request queues, and every cycle is
// checked against a transaction-level reference. That reference serves one
// request at a time, acks it 1+WAIT_STATES cycles after acceptance, and keeps
// its own copy of memory.

module tb_mips32_mem_responder;

    localparam int NINST = 3;
    localparam int DEPTH = 1024;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;

    logic        rst     [NINST];
    logic        ifReq   [NINST];
    logic [31:0] ifAddr  [NINST];
    logic        ifAck   [NINST];
    logic [31:0] ifRdata [NINST];
    logic        ifErr   [NINST];
    logic        dReq    [NINST];
    logic        dWe     [NINST];
    logic [31:0] dAddr   [NINST];
    logic [31:0] dWdata  [NINST];
    logic        dAck    [NINST];
    logic [31:0] dRdata  [NINST];
    logic        dErr    [NINST];
    logic        busy    [NINST];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference state for the instance currently under test.
    logic [31:0] refMem [DEPTH];
    bit          pend;
    bit          pendIsData;
    logic        pendWe;
    logic [31:0] pendAddr;
    logic [31:0] pendWdata;
    int          acceptCycle;
    int          ackCycle;
    int          freeCycle;
    bit          lastGrantData;
    logic [31:0] expIfRdata;
    logic [31:0] expDRdata;

    // Requester state for both ports.
    req_t ifQ[$];
    req_t dQ[$];
    bit   ifActive;
    bit   dActive;
    req_t ifCur;
    req_t dCur;

    // Free-running clock shared by all three instances.
    always #5 clk = ~clk;

    genvar g;
    generate
        for (g = 0; g < NINST; g++) begin : gInst
            mips32_mem_responder #(
                .DEPTH      (DEPTH),
                .AW         (10),
                .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 3 : 0))
            ) dut (
                .clk     (clk),
                .rst     (rst[g]),
                .if_req  (ifReq[g]),
                .if_addr (ifAddr[g]),
                .if_ack  (ifAck[g]),
                .if_rdata(ifRdata[g]),
                .if_err  (ifErr[g]),
                .d_req   (dReq[g]),
                .d_we    (dWe[g]),
                .d_addr  (dAddr[g]),
                .d_wdata (dWdata[g]),
                .d_ack   (dAck[g]),
                .d_rdata (dRdata[g]),
                .d_err   (dErr[g]),
                .busy    (busy[g])
            );
        end
    endgenerate

    function automatic int wsOf(input int i);
        case (i)
            0:       return 2;
            1:       return 3;
            default: return 0;
        endcase
    endfunction

    function automatic req_t mkReq(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.we    = we;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic logic [31:0] pickAddr();
        int sel;
        sel = $urandom_range(0, 19);
        if (sel < 16) return 32'(sel);
        if (sel == 16) return 32'd1023;
        if (sel == 17) return 32'd1024;
        if (sel == 18) return 32'hFFFF_FFFF;
        return 32'h8000_0005;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %h expected %h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    // Predict this cycle's outputs, retire a request whose ack is due, and
    // compare every output of instance i.
    task automatic evaluateCycle(input int i);
        logic expIfAck;
        logic expIfErr;
        logic expDAck;
        logic expDErr;
        logic expBusy;
        logic err;
        expIfAck = 1'b0;
        expIfErr = 1'b0;
        expDAck  = 1'b0;
        expDErr  = 1'b0;
        if (pend && cyc == ackCycle) begin
            err = (pendAddr >= 32'(DEPTH));
            if (!pendIsData) begin
                expIfAck   = 1'b1;
                expIfErr   = err;
                expIfRdata = err ? 32'd0 : refMem[pendAddr[9:0]];
                ifActive   = 1'b0;
            end else begin
                expDAck = 1'b1;
                expDErr = err;
                if (err) expDRdata = 32'd0;
                else if (pendWe) refMem[pendAddr[9:0]] = pendWdata;
                else expDRdata = refMem[pendAddr[9:0]];
                dActive = 1'b0;
            end
            pend = 1'b0;
        end
        expBusy = (cyc > acceptCycle) && (cyc < freeCycle);
        checkOutput("if_ack",   32'(ifAck[i]), 32'(expIfAck));
        checkOutput("if_err",   32'(ifErr[i]), 32'(expIfErr));
        checkOutput("if_rdata", ifRdata[i],    expIfRdata);
        checkOutput("d_ack",    32'(dAck[i]),  32'(expDAck));
        checkOutput("d_err",    32'(dErr[i]),  32'(expDErr));
        checkOutput("d_rdata",  dRdata[i],     expDRdata);
        checkOutput("busy",     32'(busy[i]),  32'(expBusy));
    endtask

    // One clock of instance i: present requests, let the reference accept
    // one if the responder is idle, advance the clock, then check outputs.
    task automatic applyStimulus(input int i, input bit rstIn);
        bit takeData;
        if (rstIn) begin
            ifQ.delete();
            dQ.delete();
            ifActive = 1'b0;
            dActive  = 1'b0;
        end
        if (!ifActive && ifQ.size() > 0) begin
            ifCur    = ifQ.pop_front();
            ifActive = 1'b1;
        end
        if (!dActive && dQ.size() > 0) begin
            dCur    = dQ.pop_front();
            dActive = 1'b1;
        end
        rst[i]    = rstIn;
        ifReq[i]  = ifActive;
        ifAddr[i] = ifCur.addr;
        dReq[i]   = dActive;
        dWe[i]    = dCur.we;
        dAddr[i]  = dCur.addr;
        dWdata[i] = dCur.wdata;
        if (!rstIn && !pend && cyc >= freeCycle && (ifActive || dActive)) begin
            takeData      = (ifActive && dActive) ? !lastGrantData : dActive;
            lastGrantData = takeData;
            pend          = 1'b1;
            pendIsData    = takeData;
            pendWe        = takeData ? dCur.we : 1'b0;
            pendAddr      = takeData ? dCur.addr : ifCur.addr;
            pendWdata     = dCur.wdata;
            acceptCycle   = cyc;
            ackCycle      = cyc + 1 + wsOf(i);
            freeCycle     = ackCycle + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rstIn) begin
            pend          = 1'b0;
            lastGrantData = 1'b0;
            expIfRdata    = 32'd0;
            expDRdata     = 32'd0;
            acceptCycle   = cyc;
            freeCycle     = cyc;
        end
        evaluateCycle(i);
    endtask

    // Run until every queued request has been acked, within a cycle budget.
    task automatic runUntilIdle(input int i, input int budget);
        int n;
        bit outstanding;
        n = 0;
        while ((pend || ifActive || dActive || ifQ.size() > 0 || dQ.size() > 0) && n < budget) begin
            applyStimulus(i, 1'b0);
            n++;
        end
        outstanding = pend || ifActive || dActive || ifQ.size() > 0 || dQ.size() > 0;
        checkOutput("drain_timeout", 32'(outstanding), 32'd0);
    endtask

    // Give every address the random phase can read a known value.
    task automatic initMem(input int i);
        for (int a = 0; a < 16; a++) dQ.push_back(mkReq(1'b1, 32'(a), $urandom));
        dQ.push_back(mkReq(1'b1, 32'd1023, $urandom));
        runUntilIdle(i, 400);
    endtask

    task automatic randomTraffic(input int i, input int cycles);
        for (int n = 0; n < cycles; n++) begin
            if (!ifActive && ifQ.size() == 0 && $urandom_range(0, 2) == 0)
                ifQ.push_back(mkReq(1'b0, pickAddr(), 32'd0));
            if (!dActive && dQ.size() == 0 && $urandom_range(0, 2) == 0)
                dQ.push_back(mkReq(1'($urandom_range(0, 1)), pickAddr(), $urandom));
            applyStimulus(i, 1'b0);
        end
        runUntilIdle(i, 200);
    endtask

    task automatic startInstance(input int i);
        pend          = 1'b0;
        ifActive      = 1'b0;
        dActive       = 1'b0;
        ifCur         = mkReq(1'b0, 32'd0, 32'd0);
        dCur          = mkReq(1'b0, 32'd0, 32'd0);
        acceptCycle   = cyc;
        freeCycle     = cyc;
        lastGrantData = 1'b0;
        applyStimulus(i, 1'b1);
        applyStimulus(i, 1'b0);
        initMem(i);
    endtask

    // Stimulus sequence: directed scenarios per instance, then random traffic.
    initial begin
        int guard;
        for (int i = 0; i < NINST; i++) begin
            rst[i] = 1'b1; ifReq[i] = 1'b0; ifAddr[i] = 32'd0;
            dReq[i] = 1'b0; dWe[i] = 1'b0; dAddr[i] = 32'd0; dWdata[i] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NINST; i++) rst[i] = 1'b0;

        $display("[TB] instance 0, WAIT_STATES=2");
        startInstance(0);
        dQ.push_back(mkReq(1'b1, 32'd5, 32'hDEAD_BEEF));
        dQ.push_back(mkReq(1'b0, 32'd5, 32'd0));
        runUntilIdle(0, 50);
        applyStimulus(0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            ifQ.push_back(mkReq(1'b0, 32'd3, 32'd0));
            dQ.push_back(mkReq(1'b0, 32'd7, 32'd0));
        end
        runUntilIdle(0, 100);
        dQ.push_back(mkReq(1'b1, 32'd1024, 32'h0000_1234));
        dQ.push_back(mkReq(1'b0, 32'd0, 32'd0));
        ifQ.push_back(mkReq(1'b0, 32'hFFFF_FFFF, 32'd0));
        runUntilIdle(0, 50);
        randomTraffic(0, 400);

        $display("[TB] instance 1, WAIT_STATES=3");
        startInstance(1);
        dQ.push_back(mkReq(1'b1, 32'd9, 32'h1111_1111));
        runUntilIdle(1, 50);
        dQ.push_back(mkReq(1'b1, 32'd9, 32'hA5A5_A5A5));
        guard = 0;
        while (!(pend && cyc > acceptCycle) && guard < 20) begin
            applyStimulus(1, 1'b0);
            guard++;
        end
        applyStimulus(1, 1'b1);
        applyStimulus(1, 1'b0);
        dQ.push_back(mkReq(1'b0, 32'd9, 32'd0));
        runUntilIdle(1, 50);
        randomTraffic(1, 300);

        $display("[TB] instance 2, WAIT_STATES=0");
        startInstance(2);
        for (int a = 0; a < 3; a++) ifQ.push_back(mkReq(1'b0, 32'(a), 32'd0));
        runUntilIdle(2, 50);
        randomTraffic(2, 300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
